counter_strobe_bank: RTL and testbench
======================================

COUNTER_STROBE_BANK -- requirements
Module: counter_strobe_bank

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, counter/period width; CHANNELS, default 4, independent channels; LATENCY, default 2, adder pipeline stages per increment (>=1).
REQ-002 Port clk SHALL be input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst SHALL be input, 1 bit; reset is rst, synchronous, active-high; clock clk.
REQ-004 Port enable SHALL be input, CHANNELS bits, per-channel count event.
REQ-005 Port arm SHALL be input, CHANNELS bits, per-channel start/rearm pulse.
REQ-006 Ports cfg_we (1), cfg_ch ($clog2(CHANNELS), min 1), cfg_period (WIDTH) and cfg_oneshot (1) SHALL be inputs forming the configuration write port.
REQ-007 Port strobe SHALL be output, CHANNELS bits, one-cycle terminal-count pulse.
REQ-008 Port ready SHALL be output, CHANNELS bits, high when that channel may accept enable.
REQ-009 Port busy SHALL be output, CHANNELS bits, high while the channel is in RUN.
REQ-010 Port overrun SHALL be output, CHANNELS bits, sticky illegal-enable flag.

Function
REQ-011 Each channel SHALL have states IDLE, RUN and DONE; arm moves IDLE/DONE->RUN, clears the count to 0 and loads the shadow period/mode into the active registers.
REQ-012 In RUN, an enable accepted while ready SHALL increment the count through a LATENCY-stage adder.
REQ-013 The accepted enable that makes the count equal the active period SHALL assert strobe exactly one cycle after the enable that completes it, for one cycle.
REQ-014 On terminal count in periodic mode the count SHALL return to 0 and the channel SHALL stay in RUN; in one-shot mode the channel SHALL go to DONE.
REQ-015 An active period of 0 SHALL never strobe; a period of 1 SHALL strobe on every accepted enable.
REQ-016 After an accepted enable, ready SHALL be low for LATENCY-1 cycles, and ready SHALL be low in IDLE and DONE.
REQ-017 Enable while !ready in RUN SHALL be ignored and SHALL set overrun; overrun is cleared only by arm or rst.
REQ-018 Enable in IDLE or DONE SHALL be ignored without setting overrun.
REQ-019 cfg_we SHALL write cfg_period/cfg_oneshot to the shadow registers of channel cfg_ch, and cfg_ch >= CHANNELS SHALL be ignored.
REQ-020 In RUN, the shadow configuration SHALL take effect on the cycle following the next terminal count, never mid-period.
REQ-021 When cfg_we and terminal count coincide on one channel, the new shadow value SHALL be the one applied.
REQ-022 If arm and enable coincide, arm SHALL win and the enable SHALL be discarded.
REQ-023 Count arithmetic SHALL be modulo 2^WIDTH, and a period of 2^WIDTH-1 SHALL strobe without wrapping past it.
REQ-024 Channels SHALL be fully independent; simultaneous strobes on all channels SHALL all be reported in the same cycle.

Reset
REQ-025 rst SHALL force all channels to IDLE, count to 0, shadow and active period to 0, mode to periodic, and all pipeline valid bits to 0.
REQ-026 During and in the cycle after rst, strobe, ready, busy and overrun SHALL all be 0.
REQ-027 rst mid-increment SHALL discard in-flight adder results, and no strobe SHALL follow reset.

Structure
REQ-028 A shared package SHALL hold the channel state enum (IDLE, RUN, DONE) and the mode encoding (PERIODIC=0, ONESHOT=1).
REQ-029 The design SHALL use one sub-module, strobe_channel, instantiated CHANNELS times, each using the existing adder_pipelined for its increment.
REQ-030 The top level SHALL contain only configuration decode and vector concatenation.

Verification
REQ-031 Bench SHALL cover: WIDTH=8, LATENCY=2, ch0 period 3 periodic, arm, enable whenever ready -> strobe on the 3rd, 6th and 9th accepted enables, ready low 1 cycle after each enable.
REQ-032 Bench SHALL cover: ch1 period 2 one-shot, arm, 4 enables -> single strobe, busy drops, ready=0, no further strobes.
REQ-033 Bench SHALL cover: ch2 enable while ready=0 -> overrun=1, count unchanged, overrun cleared by the next arm.
REQ-034 Bench SHALL cover: ch0 period 4, write period 2 after 1 enable -> next strobe at the 4th enable, then every 2nd enable.
REQ-035 Bench SHALL cover: all channels period 1, enable all -> strobe=4'b1111 in one cycle; rst on the next cycle -> all outputs 0 and no strobe follows.
REQ-036 Bench SHALL cover: period 0, 20 enables -> no strobe and overrun stays 0.

Source files
------------

// File: rtl/counter_strobe_bank_pkg.sv
// Shared definitions for the counter/strobe bank.
//   ch_state_t     : per-channel state (IDLE, RUN, DONE)
//   MODE_*         : channel mode encoding, PERIODIC=0, ONESHOT=1
//   sel_width()    : width of a channel-select field, never below 1 bit
package counter_strobe_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_pipelined.sv
// Pipelined adder: sum = a + b (modulo 2^WIDTH), LATENCY register stages.
//   clk, rst      : clock, synchronous active-high clear of all valid bits
//   in_valid, a, b: operands, captured on the rising edge when in_valid
//   out_valid, sum: result, valid LATENCY cycles after launch
//   in_flight     : a launched operation has not yet reached the output stage
module adder_pipelined #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             in_flight
);

    logic [LATENCY:1]            vld_pipe;
    logic [LATENCY:1][WIDTH-1:0] sum_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // Data stages carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        sum_pipe[1] <= a + b;
        for (int i = 2; i <= LATENCY; i++) begin
            sum_pipe[i] <= sum_pipe[i-1];
        end
    end

    // Only stages before the last count as pending: the last stage is
    // visible on sum this cycle and can be forwarded by the consumer.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 1; i < LATENCY; i++) begin
            in_flight = in_flight | vld_pipe[i];
        end
    end

    assign out_valid = vld_pipe[LATENCY];
    assign sum       = sum_pipe[LATENCY];

endmodule

// File: rtl/strobe_channel.sv
// One counter/strobe channel.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : count event, accepted only while ready
//   arm          : (re)start: count <= 0, shadow config -> active, go RUN
//   cfg_we       : write cfg_period/cfg_oneshot into the shadow registers
//   strobe       : one-cycle pulse the cycle after the terminal-count enable
//   ready        : RUN and no increment pending
//   busy         : channel is in RUN
//   overrun      : sticky, enable seen in RUN while not ready
module strobe_channel
    import counter_strobe_bank_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             arm,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_oneshot,
    output logic             strobe,
    output logic             ready,
    output logic             busy,
    output logic             overrun
);

    ch_state_t        state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] shadow_period, active_period;
    logic             shadow_mode, active_mode;
    logic             strobe_q, overrun_q;

    logic             add_valid, add_in_flight, flush;
    logic [WIDTH-1:0] add_sum, add_a, add_b;

    logic [WIDTH-1:0] count_eff, count_inc, next_period;
    logic             next_mode, is_run, ready_int, accept, illegal, terminal;

    always_comb begin
        // Forward a result that lands this cycle so back-to-back
        // increments see the up-to-date count.
        count_eff = add_valid ? add_sum : count_q;
        count_inc = count_eff + WIDTH'(1);
        is_run    = (state == ST_RUN);
        ready_int = is_run && !add_in_flight;
        accept    = enable && ready_int && !arm;
        illegal   = enable && is_run && add_in_flight && !arm;
        terminal  = accept && (active_period != '0) && (count_inc == active_period);
        // On terminal count the adder produces 0 instead of the increment,
        // so the wrap rides the same pipeline and ready timing is unchanged.
        add_a     = terminal ? '0 : count_eff;
        add_b     = terminal ? '0 : WIDTH'(1);
        // A config write landing with arm/terminal count is the one applied.
        next_period = cfg_we ? cfg_period  : shadow_period;
        next_mode   = cfg_we ? cfg_oneshot : shadow_mode;
    end

    // Arm discards anything still in the adder.
    assign flush = rst || arm;

    adder_pipelined #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) u_add (
        .clk      (clk),
        .rst      (flush),
        .in_valid (accept),
        .a        (add_a),
        .b        (add_b),
        .out_valid(add_valid),
        .sum      (add_sum),
        .in_flight(add_in_flight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count_q       <= '0;
            shadow_period <= '0;
            active_period <= '0;
            shadow_mode   <= MODE_PERIODIC;
            active_mode   <= MODE_PERIODIC;
            strobe_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            strobe_q <= terminal;
            if (cfg_we) begin
                shadow_period <= cfg_period;
                shadow_mode   <= cfg_oneshot;
            end
            if (add_valid) begin
                count_q <= add_sum;
            end
            if (arm) begin
                state         <= ST_RUN;
                count_q       <= '0;
                active_period <= next_period;
                active_mode   <= next_mode;
                overrun_q     <= 1'b0;
            end else begin
                if (illegal) begin
                    overrun_q <= 1'b1;
                end
                if (terminal) begin
                    active_period <= next_period;
                    active_mode   <= next_mode;
                    if (active_mode == MODE_ONESHOT) begin
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

    // Outputs are held low while rst is asserted.
    assign strobe  = strobe_q  && !rst;
    assign ready   = ready_int && !rst;
    assign busy    = is_run    && !rst;
    assign overrun = overrun_q && !rst;

endmodule

// File: rtl/counter_strobe_bank.sv
// Bank of CHANNELS independent counter/strobe channels.
//   clk, rst                 : clock, synchronous active-high reset
//   enable[CHANNELS]         : per-channel count event
//   arm[CHANNELS]            : per-channel start/rearm
//   cfg_we/cfg_ch/cfg_period/cfg_oneshot : shadow config write port;
//                              cfg_ch values with no channel are ignored
//   strobe/ready/busy/overrun[CHANNELS]  : per-channel status
module counter_strobe_bank
    import counter_strobe_bank_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    parameter int  LATENCY  = 2,
    localparam int CH_W     = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] arm,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_oneshot,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] ready,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] overrun
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic hit;
        assign hit = cfg_we && (cfg_ch == CH_W'(i));

        strobe_channel #(
            .WIDTH  (WIDTH),
            .LATENCY(LATENCY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable[i]),
            .arm        (arm[i]),
            .cfg_we     (hit),
            .cfg_period (cfg_period),
            .cfg_oneshot(cfg_oneshot),
            .strobe     (strobe[i]),
            .ready      (ready[i]),
            .busy       (busy[i]),
            .overrun    (overrun[i])
        );
    end

endmodule

// File: tb/tb_counter_strobe_bank.sv
// Bench for counter_strobe_bank (WIDTH=8, CHANNELS=4, LATENCY=2).
// A per-channel behavioural model (count updated at once, ready as a
// countdown of blocked cycles) predicts every output every cycle; directed
// sections add checks on strobe positions in units of accepted enables.
module tb_counter_strobe_bank;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int LAT = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] enable, arm;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_period;
    logic           cfg_oneshot;
    logic [NCH-1:0] strobe, ready, busy, overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_st[NCH], m_cnt[NCH], m_per[NCH], m_mode[NCH];
    int m_sper[NCH], m_smode[NCH], m_wait[NCH];
    bit m_ovr[NCH], m_strb[NCH];

    always #5 clk = ~clk;

    counter_strobe_bank #(.WIDTH(W), .CHANNELS(NCH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .arm(arm),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .strobe(strobe), .ready(ready), .busy(busy), .overrun(overrun)
    );

    function automatic bit m_ready(int c);
        return (m_st[c] == M_RUN) && (m_wait[c] == 0);
    endfunction

    task automatic model_tick(bit r, logic [NCH-1:0] en, logic [NCH-1:0] a,
                              bit we, int ch, int pp, bit os);
        for (int c = 0; c < NCH; c++) begin
            bit rdy;
            int old_mode;
            if (r) begin
                m_st[c] = M_IDLE; m_cnt[c] = 0; m_per[c] = 0; m_mode[c] = 0;
                m_sper[c] = 0; m_smode[c] = 0; m_wait[c] = 0;
                m_ovr[c] = 0; m_strb[c] = 0;
                continue;
            end
            rdy = m_ready(c);
            m_strb[c] = 0;
            if (we && ch == c) begin
                m_sper[c]  = pp;
                m_smode[c] = int'(os);
            end
            if (m_wait[c] > 0) m_wait[c]--;
            if (a[c]) begin
                m_st[c] = M_RUN; m_cnt[c] = 0; m_per[c] = m_sper[c];
                m_mode[c] = m_smode[c]; m_ovr[c] = 0; m_wait[c] = 0;
            end else if (en[c] && m_st[c] == M_RUN) begin
                if (!rdy) begin
                    m_ovr[c] = 1;
                end else begin
                    m_cnt[c]  = (m_cnt[c] + 1) % (1 << W);
                    m_wait[c] = LAT - 1;
                    if (m_per[c] != 0 && m_cnt[c] == m_per[c]) begin
                        m_strb[c] = 1;
                        m_cnt[c]  = 0;
                        old_mode  = m_mode[c];
                        m_per[c]  = m_sper[c];
                        m_mode[c] = m_smode[c];
                        if (old_mode == 1) m_st[c] = M_DONE;
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [NCH-1:0] got, logic [NCH-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, want);
        end
    endtask

    task automatic chk_int(string tag, int got, int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, want);
        end
    endtask

    task automatic step(bit r, logic [NCH-1:0] en, logic [NCH-1:0] a,
                        bit we, int ch, int pp, bit os);
        logic [NCH-1:0] es, er, eb, eo;
        rst = r; enable = en; arm = a; cfg_we = we;
        cfg_ch = 2'(ch); cfg_period = W'(pp); cfg_oneshot = os;
        model_tick(r, en, a, we, ch, pp, os);
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            es[c] = m_strb[c];
            er[c] = m_ready(c);
            eb[c] = (m_st[c] == M_RUN);
            eo[c] = m_ovr[c];
        end
        chk("strobe", strobe, es);
        chk("ready", ready, er);
        chk("busy", busy, eb);
        chk("overrun", overrun, eo);
    endtask

    task automatic tick(logic [NCH-1:0] en, logic [NCH-1:0] a);
        step(1'b0, en, a, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic cfg(int ch, int pp, bit os);
        step(1'b0, '0, '0, 1'b1, ch, pp, os);
    endtask

    initial begin
        int hits[$];
        int acc;
        int nstb;
        logic [NCH-1:0] e;

        // Reset
        step(1'b1, '0, '0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 4'b1111, 4'b1111, 1'b0, 0, 0, 1'b0);
        tick('0, '0);

        // ch0 period 3 periodic, enable whenever ready
        cfg(0, 3, 1'b0);
        tick('0, 4'b0001);
        acc = 0;
        for (int k = 0; k < 40 && acc < 9; k++) begin
            e = m_ready(0) ? 4'b0001 : 4'b0000;
            tick(e, '0);
            if (e[0]) acc++;
            if (strobe[0]) hits.push_back(acc);
        end
        chk_int("A_nstrobe", hits.size(), 3);
        chk_int("A_hit1", (hits.size() > 0) ? hits[0] : -1, 3);
        chk_int("A_hit2", (hits.size() > 1) ? hits[1] : -1, 6);
        chk_int("A_hit3", (hits.size() > 2) ? hits[2] : -1, 9);

        // ch1 period 2 one-shot, 4 enables
        cfg(1, 2, 1'b1);
        tick('0, 4'b0010);
        nstb = 0;
        for (int k = 0; k < 8; k++) begin
            e = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(e, '0);
            if (strobe[1]) nstb++;
        end
        tick(4'b0010, '0);
        if (strobe[1]) nstb++;
        chk_int("B_nstrobe", nstb, 1);
        chk_int("B_busy", int'(busy[1]), 0);
        chk_int("B_ready", int'(ready[1]), 0);

        // ch2 enable while not ready -> overrun, count unchanged
        cfg(2, 5, 1'b0);
        tick('0, 4'b0100);
        tick(4'b0100, '0);
        tick(4'b0100, '0);
        chk_int("C_overrun_set", int'(overrun[2]), 1);
        acc = 1;
        for (int k = 0; k < 30; k++) begin
            e = m_ready(2) ? 4'b0100 : 4'b0000;
            tick(e, '0);
            if (e[2]) acc++;
            if (strobe[2]) break;
        end
        chk_int("C_acc_at_strobe", acc, 5);
        chk_int("C_overrun_sticky", int'(overrun[2]), 1);
        tick('0, 4'b0100);
        chk_int("C_overrun_clr", int'(overrun[2]), 0);

        // ch0 period 4, rewrite to 2 after one enable
        cfg(0, 4, 1'b0);
        tick('0, 4'b0001);
        tick(4'b0001, '0);
        cfg(0, 2, 1'b0);
        acc = 1;
        hits.delete();
        for (int k = 0; k < 40 && acc < 8; k++) begin
            e = m_ready(0) ? 4'b0001 : 4'b0000;
            tick(e, '0);
            if (e[0]) acc++;
            if (strobe[0]) hits.push_back(acc);
        end
        chk_int("D_nstrobe", hits.size(), 3);
        chk_int("D_hit1", (hits.size() > 0) ? hits[0] : -1, 4);
        chk_int("D_hit2", (hits.size() > 1) ? hits[1] : -1, 6);
        chk_int("D_hit3", (hits.size() > 2) ? hits[2] : -1, 8);

        // All channels period 1, simultaneous strobe, then reset mid-flight
        for (int c = 0; c < NCH; c++) cfg(c, 1, 1'b0);
        tick('0, 4'b1111);
        tick(4'b1111, '0);
        chk("E_all_strobe", strobe, 4'b1111);
        step(1'b1, 4'b1111, '0, 1'b0, 0, 0, 1'b0);
        chk("E_rst_strobe", strobe, '0);
        chk("E_rst_ready", ready, '0);
        chk("E_rst_busy", busy, '0);
        chk("E_rst_ovr", overrun, '0);
        nstb = 0;
        for (int k = 0; k < 4; k++) begin
            tick('0, '0);
            if (strobe != '0) nstb++;
        end
        chk_int("E_no_strobe_after_rst", nstb, 0);

        // Period 0: never strobes, never overruns when enabled on ready
        cfg(3, 0, 1'b0);
        tick('0, 4'b1000);
        acc = 0;
        nstb = 0;
        for (int k = 0; k < 60 && acc < 20; k++) begin
            e = m_ready(3) ? 4'b1000 : 4'b0000;
            tick(e, '0);
            if (e[3]) acc++;
            if (strobe[3]) nstb++;
        end
        chk_int("F_enables", acc, 20);
        chk_int("F_nstrobe", nstb, 0);
        chk_int("F_overrun", int'(overrun[3]), 0);

        // Period 2^W-1: strobe on the 255th enable only
        cfg(0, 255, 1'b0);
        tick('0, 4'b0001);
        acc = 0;
        hits.delete();
        for (int k = 0; k < 700 && acc < 256; k++) begin
            e = m_ready(0) ? 4'b0001 : 4'b0000;
            tick(e, '0);
            if (e[0]) acc++;
            if (strobe[0]) hits.push_back(acc);
        end
        chk_int("G_nstrobe", hits.size(), 1);
        chk_int("G_hit", (hits.size() > 0) ? hits[0] : -1, 255);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit r, we, os;
            int ch, pp;
            logic [NCH-1:0] a;
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 4) == 0);
            ch = $urandom_range(0, NCH - 1);
            pp = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 4);
            os = $urandom_range(0, 1);
            for (int c = 0; c < NCH; c++) a[c] = ($urandom_range(0, 29) == 0);
            e = NCH'($urandom);
            step(r, e, a, we, ch, pp, os);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
